pipe_decode_ctrl: RTL

Registered decode-and-issue stage for the pipelined ECE550 core. It decodes 32-bit instructions into the control bundle used by execute, memory and writeback, and holds the result in a one-entry output register behind valid/ready handshakes. It also detects load-use hazards through a parametrised scoreboard, holds off issue while a multicycle mul/div is in flight, and supports flush on a taken branch or jump.

---
 rtl/pipe_decode_ctrl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_decode_ctrl.sv
// Decode-and-issue stage: decodes one instruction into the execute/memory/writeback
// control bundle, holds it in a one-entry output register and gates issue on hazards.
module pipe_decode_ctrl #(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int SB_DEPTH        = 4,
    parameter int MD_LAT          = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_insn,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic [4:0]  out_aluop,
    output logic        out_alu_inb,
    output logic        out_wren,
    output logic        out_we,
    output logic        out_rwd,
    output logic        out_rdst,
    output logic        out_jal,
    output logic        out_jp,
    output logic        out_jr,
    output logic        out_bne,
    output logic        out_blt,
    output logic        out_bex,
    output logic        out_setx,
    output logic [4:0]  out_rd,
    output logic        md_busy
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    localparam int              MD_W    = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam logic [MD_W-1:0] MD_INIT = MD_W'(MD_LAT - 1);

    // True when a non-zero register rd is read by any enabled source field.
    function automatic logic src_hit(input logic [4:0] rd,
                                     input logic [4:0] rs, input logic rs_en,
                                     input logic [4:0] rt, input logic rt_en,
                                     input logic [4:0] rf, input logic rf_en);
        return (rd != 5'd0) &&
               ((rs_en && (rs == rd)) || (rt_en && (rt == rd)) || (rf_en && (rf == rd)));
    endfunction

    logic        is_add_s, is_j_s, is_bne_s, is_jal_s, is_jr_s, is_addi_s;
    logic        is_blt_s, is_sw_s, is_lw_s, is_setx_s, is_bex_s;
    logic [11:0] dec_flags_s;
    logic [4:0]  dec_aluop_s;
    logic [4:0]  dec_rd_s;
    logic        dec_md_s;
    logic        rs_en_s, rt_en_s, rf_en_s;
    logic        stall_s;
    logic        accept_s;
    logic        issue_s;
    logic [MD_W-1:0] md_cnt_next_s;

    logic        out_valid_r;
    logic [31:0] out_insn_r;
    logic [4:0]  out_aluop_r;
    logic [11:0] out_flags_r;
    logic [4:0]  out_rd_r;
    logic        out_md_r;
    logic [SB_DEPTH-1:0] sb_valid_r;
    logic [SB_DEPTH-1:0] sb_load_r;
    logic [4:0]          sb_rd_r [SB_DEPTH];
    logic [MD_W-1:0]     md_cnt_r;
    logic                md_busy_r;

    // Opcode decode of the incoming instruction.
    always_comb begin
        is_add_s  = 1'b0;
        is_j_s    = 1'b0;
        is_bne_s  = 1'b0;
        is_jal_s  = 1'b0;
        is_jr_s   = 1'b0;
        is_addi_s = 1'b0;
        is_blt_s  = 1'b0;
        is_sw_s   = 1'b0;
        is_lw_s   = 1'b0;
        is_setx_s = 1'b0;
        is_bex_s  = 1'b0;
        case (in_insn[31:27])
            OP_ADD:  is_add_s  = 1'b1;
            OP_J:    is_j_s    = 1'b1;
            OP_BNE:  is_bne_s  = 1'b1;
            OP_JAL:  is_jal_s  = 1'b1;
            OP_JR:   is_jr_s   = 1'b1;
            OP_ADDI: is_addi_s = 1'b1;
            OP_BLT:  is_blt_s  = 1'b1;
            OP_SW:   is_sw_s   = 1'b1;
            OP_LW:   is_lw_s   = 1'b1;
            OP_SETX: is_setx_s = 1'b1;
            OP_BEX:  is_bex_s  = 1'b1;
            default: is_add_s  = 1'b0;
        endcase
    end

    // Control bundle fields, destination and source enables.
    always_comb begin
        dec_flags_s = {is_addi_s | is_sw_s | is_lw_s,
                       is_sw_s,
                       is_add_s | is_addi_s | is_lw_s | is_jal_s | is_setx_s,
                       is_lw_s,
                       is_addi_s | is_sw_s | is_lw_s | is_bne_s | is_jr_s | is_blt_s,
                       is_jal_s,
                       is_j_s | is_jal_s,
                       is_jr_s,
                       is_bne_s,
                       is_blt_s,
                       is_bex_s,
                       is_setx_s};
        if (is_addi_s || is_sw_s || is_lw_s) begin
            dec_aluop_s = 5'b00000;
        end else if (is_bne_s || is_blt_s) begin
            dec_aluop_s = 5'b00001;
        end else begin
            dec_aluop_s = in_insn[6:2];
        end
        if (is_add_s || is_addi_s || is_lw_s) begin
            dec_rd_s = in_insn[26:22];
        end else if (is_jal_s) begin
            dec_rd_s = 5'd31;
        end else if (is_setx_s) begin
            dec_rd_s = 5'd30;
        end else begin
            dec_rd_s = 5'd0;
        end
        dec_md_s = is_add_s && ((in_insn[6:2] == 5'b00110) || (in_insn[6:2] == 5'b00111));
        rs_en_s  = is_add_s | is_addi_s | is_lw_s | is_sw_s | is_bne_s | is_blt_s;
        rt_en_s  = is_add_s;
        rf_en_s  = is_sw_s | is_bne_s | is_blt_s | is_jr_s;
    end

    // Load-use hazard: a load still in the output register, or a recently issued one.
    always_comb begin
        stall_s = out_valid_r && out_flags_r[8] &&
                  src_hit(out_rd_r, in_insn[21:17], rs_en_s, in_insn[16:12], rt_en_s,
                          in_insn[26:22], rf_en_s);
        for (int i = 0; i < SB_DEPTH; i++) begin
            stall_s = stall_s | ((i < LOAD_USE_CYCLES) && sb_valid_r[i] && sb_load_r[i] &&
                      src_hit(sb_rd_r[i], in_insn[21:17], rs_en_s, in_insn[16:12], rt_en_s,
                              in_insn[26:22], rf_en_s));
        end
    end

    assign in_ready = reset & (~out_valid_r | out_ready) & ~stall_s & ~md_busy_r & ~flush;
    assign accept_s = in_valid & in_ready;
    assign issue_s  = out_valid_r & out_ready & ~flush;

    // Next mul/div countdown value; a fresh issue reloads the counter.
    always_comb begin
        if (issue_s && out_md_r) begin
            md_cnt_next_s = MD_INIT;
        end else if (md_cnt_r != '0) begin
            md_cnt_next_s = md_cnt_r - MD_W'(1);
        end else begin
            md_cnt_next_s = md_cnt_r;
        end
    end

    // One-entry output register holding the decoded bundle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_insn_r  <= 32'd0;
            out_aluop_r <= 5'd0;
            out_flags_r <= 12'd0;
            out_rd_r    <= 5'd0;
            out_md_r    <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_insn_r  <= in_insn;
            out_aluop_r <= dec_aluop_s;
            out_flags_r <= dec_flags_s;
            out_rd_r    <= dec_rd_s;
            out_md_r    <= dec_md_s;
        end else if (flush || out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Scoreboard shift register; entry index is the age since issue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sb_valid_r <= '0;
            sb_load_r  <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_rd_r[i] <= 5'd0;
            end
        end else begin
            for (int i = SB_DEPTH - 1; i > 0; i--) begin
                sb_valid_r[i] <= sb_valid_r[i-1];
                sb_load_r[i]  <= sb_load_r[i-1];
                sb_rd_r[i]    <= sb_rd_r[i-1];
            end
            sb_valid_r[0] <= issue_s;
            sb_load_r[0]  <= issue_s & out_flags_r[8];
            sb_rd_r[0]    <= issue_s ? out_rd_r : 5'd0;
        end
    end

    // Mul/div occupancy counter and its registered busy flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            md_cnt_r  <= '0;
            md_busy_r <= 1'b0;
        end else begin
            md_cnt_r  <= md_cnt_next_s;
            md_busy_r <= (md_cnt_next_s != '0);
        end
    end

    assign out_valid = out_valid_r;
    assign out_insn  = out_insn_r;
    assign out_aluop = out_aluop_r;
    assign out_rd    = out_rd_r;
    assign md_busy   = md_busy_r;
    assign {out_alu_inb, out_wren, out_we, out_rwd, out_rdst, out_jal,
            out_jp, out_jr, out_bne, out_blt, out_bex, out_setx} = out_flags_r;

endmodule
